wbuf_read_responder: RTL and testbench
======================================

# wbuf_read_responder

Write-buffer read responder: answers the SRAM controller's write-buffer read requests with the 128-bit data parked in the write buffer. It holds per-channel write data deposited by the crossbar. Each `rc_wbuf_req` is served in order with one returned beat on `rc_wbuf_rtn`, and the entry is released on read. It sits between the crossbar write-data path and the SRAM controller's write/linefill data path.

## Interface
- `ENTRIES_PER_CH`, default 4: entries per channel, power of two, 2..64. Total entries = 4 × `ENTRIES_PER_CH`.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `xbar_wbuf_valid_i`, input, 1: crossbar write of one entry.
- `xbar_wbuf_ready_o`, output, 1: write accepted.
- `xbar_wbuf_channel_id_i`, input, 2: channel of the write.
- `xbar_wbuf_wbuffer_id_i`, input, 8: entry id; only the low log2(`ENTRIES_PER_CH`) bits are used.
- `xbar_wbuf_data_i`, input, 128: write data.
- `rc_wbuf_req_valid_i`, input, 1: read request.
- `rc_wbuf_req_ready_o`, output, 1: request accepted.
- `rc_wbuf_req_channel_id_i`, input, 2: channel of the request.
- `rc_wbuf_req_wbuffer_id_i`, input, 8: entry id, low bits used.
- `rc_wbuf_rtn_valid_o`, output, 1: return beat valid.
- `rc_wbuf_rtn_ready_i`, input, 1: return beat consumed.
- `rc_wbuf_rtn_data_o`, output, 128: return data.
- `wbuf_free_cnt_o`, output, 7: number of invalid (free) entries.
- `wbuf_rd_err_o`, output, 1: present only with `WBUF_RD_ERR_EN`; sticky flag for a read of an invalid entry.
- `wbuf_rd_err_cnt_o`, output, 8: present only with `WBUF_RD_ERR_EN`; saturating count of such reads.

## Operation
- Storage: 4 × `ENTRIES_PER_CH` entries, each 128-bit data plus a valid bit. Index = {channel_id, wbuffer_id[IDX_W-1:0]}.
- Write:
  - `xbar_wbuf_ready_o` = !valid[write index], combinational.
  - On a write handshake: data is stored and valid is set at the clock edge.
- Read request:
  - `rc_wbuf_req_ready_o` = !rtn_valid_q | `rc_wbuf_rtn_ready_i` (one-deep output register, full throughput).
  - On a request handshake: data[index] is loaded into the return register, rtn_valid_q is set, and valid[index] is cleared (entry released).
- Read of an invalid entry: return data = 128'h0, the beat is still returned, and the error is recorded when the macro is enabled.
- Return: the beat is held stable while valid & !ready. It is dropped on the handshake unless a new request is accepted in the same cycle.
- Same-cycle write and read to the same index: this is only possible when the entry is invalid. The read sees pre-write state (zeros, error), and the write then sets valid.
- Same-cycle write and read to different indices: both proceed independently.
- Free counter: +1 on each read of a valid entry, −1 on each write, net 0 when both occur. It stays within 0..4 × `ENTRIES_PER_CH`.
- Values out of reset:
  - All valid bits = 0.
  - rtn_valid_q = 0 and rtn data = 0.
  - `wbuf_free_cnt_o` = 4 × `ENTRIES_PER_CH`.
  - Error flag and error count = 0.
  - Data array is not reset.
- Reset mid-operation: any in-flight return beat is discarded and all entries are invalidated.

## Timing
- Request accepted in cycle N → `rc_wbuf_rtn_valid_o` high in cycle N+1. One request per cycle is sustained when `rc_wbuf_rtn_ready_i` is held high.
- Write handshake in cycle N → entry readable by a request in cycle N+1 or later.
- Under backpressure (rtn_valid & !ready): `rc_wbuf_req_ready_o` = 0, and data and valid stay frozen.
- Both ready outputs are combinational from state and inputs. There is no combinational path from a valid input to its own ready.
- Returns come back in request order; there are no ids on the return.

## Configuration
- `WBUF_RD_ERR_EN` defined:
  - `wbuf_rd_err_o` sets on any accepted request to an invalid entry and clears only on reset.
  - `wbuf_rd_err_cnt_o` increments by 1 on each such request and saturates at 255.
- `WBUF_RD_ERR_EN` undefined: both ports and their logic are absent, and invalid reads silently return zeros.

## Structure
- Shared package `wbuf_pkg` holds:
  - channel count 4, channel-id width 2, wbuffer-id width 8, data width 128;
  - the index-forming function;
  - the entry typedef (valid plus data).
- One sub-module, `wbuf_entry_array`: storage plus valid bits, one write port, one read-and-release port, and the free counter. The top level holds the handshakes, the return register, and the error logic.

## Test plan
- Reset, then write ch1/id2 with data A, then request ch1/id2 → return A one cycle after acceptance; free count goes 16 → 15 → 16.
- Second write to ch1/id2 while it is valid → `xbar_wbuf_ready_o` = 0 until it is read. The write then completes one cycle after the read handshake.
- Back-to-back requests to 4 valid entries with `rc_wbuf_rtn_ready_i` = 1 → 4 consecutive return beats in order. With ready held low for 3 cycles: data stable, `rc_wbuf_req_ready_o` = 0, no loss.
- Request ch3/id0 never written → return 128'h0. With `WBUF_RD_ERR_EN`: flag = 1 and count = 1. 300 such reads → count = 255.
- Same-cycle write and read of invalid ch0/id1 → return 0 (error) and the entry becomes valid. A follow-up read returns the written data.
- Assert `rst_n` low while a return beat is stalled → `rc_wbuf_rtn_valid_o` drops immediately, free count = 16, and the entry is unreadable after reset.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared constants, entry type and index helper for the write-buffer read responder.
package wbuf_pkg;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_ID_W = 2;
    localparam int unsigned WB_ID_W = 8;
    localparam int unsigned DATA_W  = 128;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

    // Flat entry index {channel, low idx_w bits of the entry id}.
    function automatic logic [WB_ID_W-1:0] wbuf_index(
        input logic [CH_ID_W-1:0] ch,
        input logic [WB_ID_W-1:0] id,
        input int unsigned        idx_w
    );
        logic [WB_ID_W-1:0] mask;
        mask = WB_ID_W'((1 << idx_w) - 1);
        return (WB_ID_W'(ch) << idx_w) | (id & mask);
    endfunction

endpackage

// File: rtl/wbuf_entry_array.sv
// Write-buffer storage: data plus valid bits, one write port, one read-and-release
// port and the free-entry counter.
module wbuf_entry_array
    import wbuf_pkg::*;
#(
    parameter int unsigned ENTRIES_PER_CH = 4
)
(
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          i_wr_en,
    input  logic [$clog2(ENTRIES_PER_CH)+CH_ID_W-1:0]     i_wr_idx,
    input  logic [DATA_W-1:0]                             i_wr_data,
    output logic                                          o_wr_ready,
    input  logic                                          i_rd_en,
    input  logic [$clog2(ENTRIES_PER_CH)+CH_ID_W-1:0]     i_rd_idx,
    output wbuf_entry_t                                   o_rd_entry,
    output logic [6:0]                                    o_free_cnt
);

    localparam int unsigned N         = NUM_CH * ENTRIES_PER_CH;
    localparam logic [8:0]  FREE_INIT = 9'(N);

    logic [DATA_W-1:0] r_mem [N];
    logic [N-1:0]      r_valid;
    logic [8:0]        r_free_cnt;
    logic              w_rd_hit;

    assign o_wr_ready       = !r_valid[i_wr_idx];
    assign o_rd_entry.valid = r_valid[i_rd_idx];
    assign o_rd_entry.data  = r_mem[i_rd_idx];
    assign w_rd_hit         = i_rd_en & r_valid[i_rd_idx];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Set after clear: a same-index write and read leaves the entry valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            if (i_rd_en) begin
                r_valid[i_rd_idx] <= 1'b0;
            end
            if (i_wr_en) begin
                r_valid[i_wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free_cnt <= FREE_INIT;
        end else begin
            case ({i_wr_en, w_rd_hit})
                2'b10:   r_free_cnt <= r_free_cnt - 9'd1;
                2'b01:   r_free_cnt <= r_free_cnt + 9'd1;
                default: r_free_cnt <= r_free_cnt;
            endcase
        end
    end

    // The 7-bit port cannot represent the largest configurations; it pins at 127.
    assign o_free_cnt = (r_free_cnt > 9'd127) ? 7'h7F : r_free_cnt[6:0];

endmodule

// File: rtl/wbuf_read_responder.sv
// Write-buffer read responder: in-order one-beat returns from the write buffer.
// Optional invalid-read error flag/counter enabled by defining WBUF_RD_ERR_EN.
module wbuf_read_responder
    import wbuf_pkg::*;
#(
    parameter int unsigned ENTRIES_PER_CH = 4
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                xbar_wbuf_valid_i,
    output logic                xbar_wbuf_ready_o,
    input  logic [CH_ID_W-1:0]  xbar_wbuf_channel_id_i,
    input  logic [WB_ID_W-1:0]  xbar_wbuf_wbuffer_id_i,
    input  logic [DATA_W-1:0]   xbar_wbuf_data_i,
    input  logic                rc_wbuf_req_valid_i,
    output logic                rc_wbuf_req_ready_o,
    input  logic [CH_ID_W-1:0]  rc_wbuf_req_channel_id_i,
    input  logic [WB_ID_W-1:0]  rc_wbuf_req_wbuffer_id_i,
    output logic                rc_wbuf_rtn_valid_o,
    input  logic                rc_wbuf_rtn_ready_i,
    output logic [DATA_W-1:0]   rc_wbuf_rtn_data_o,
    output logic [6:0]          wbuf_free_cnt_o
`ifdef WBUF_RD_ERR_EN
    ,
    output logic                wbuf_rd_err_o,
    output logic [7:0]          wbuf_rd_err_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES_PER_CH);
    localparam int unsigned AW    = IDX_W + CH_ID_W;

    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;
    logic              w_wr_ready;
    logic              w_wr_fire;
    logic              w_req_fire;
    wbuf_entry_t       w_rd_entry;
    logic              r_rtn_valid;
    logic [DATA_W-1:0] r_rtn_data;

    assign w_wr_idx = AW'(wbuf_index(xbar_wbuf_channel_id_i, xbar_wbuf_wbuffer_id_i, IDX_W));
    assign w_rd_idx = AW'(wbuf_index(rc_wbuf_req_channel_id_i, rc_wbuf_req_wbuffer_id_i, IDX_W));

    assign xbar_wbuf_ready_o   = w_wr_ready;
    assign rc_wbuf_req_ready_o = !r_rtn_valid | rc_wbuf_rtn_ready_i;
    assign w_wr_fire           = xbar_wbuf_valid_i & w_wr_ready;
    assign w_req_fire          = rc_wbuf_req_valid_i & rc_wbuf_req_ready_o;

    wbuf_entry_array #(
        .ENTRIES_PER_CH (ENTRIES_PER_CH)
    ) u_entry_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_fire),
        .i_wr_idx   (w_wr_idx),
        .i_wr_data  (xbar_wbuf_data_i),
        .o_wr_ready (w_wr_ready),
        .i_rd_en    (w_req_fire),
        .i_rd_idx   (w_rd_idx),
        .o_rd_entry (w_rd_entry),
        .o_free_cnt (wbuf_free_cnt_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rtn_valid <= 1'b0;
            r_rtn_data  <= '0;
        end else if (w_req_fire) begin
            r_rtn_valid <= 1'b1;
            r_rtn_data  <= w_rd_entry.valid ? w_rd_entry.data : '0;
        end else if (rc_wbuf_rtn_ready_i) begin
            r_rtn_valid <= 1'b0;
        end
    end

    assign rc_wbuf_rtn_valid_o = r_rtn_valid;
    assign rc_wbuf_rtn_data_o  = r_rtn_data;

`ifdef WBUF_RD_ERR_EN
    logic       r_rd_err;
    logic [7:0] r_rd_err_cnt;
    logic       w_err_hit;

    assign w_err_hit = w_req_fire & !w_rd_entry.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_err     <= 1'b0;
            r_rd_err_cnt <= '0;
        end else if (w_err_hit) begin
            r_rd_err <= 1'b1;
            if (r_rd_err_cnt != 8'hFF) begin
                r_rd_err_cnt <= r_rd_err_cnt + 8'd1;
            end
        end
    end

    assign wbuf_rd_err_o     = r_rd_err;
    assign wbuf_rd_err_cnt_o = r_rd_err_cnt;
`else
    // Invalid reads return zeros and are not recorded.
`endif

endmodule

// File: tb/tb_wbuf_read_responder.sv
// Self-checking bench for wbuf_read_responder against a queue/array reference model.
module tb_wbuf_read_responder;

    localparam int E = 4;
    localparam int N = 4 * E;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         xbar_wbuf_valid_i;
    logic         xbar_wbuf_ready_o;
    logic [1:0]   xbar_wbuf_channel_id_i;
    logic [7:0]   xbar_wbuf_wbuffer_id_i;
    logic [127:0] xbar_wbuf_data_i;
    logic         rc_wbuf_req_valid_i;
    logic         rc_wbuf_req_ready_o;
    logic [1:0]   rc_wbuf_req_channel_id_i;
    logic [7:0]   rc_wbuf_req_wbuffer_id_i;
    logic         rc_wbuf_rtn_valid_o;
    logic         rc_wbuf_rtn_ready_i;
    logic [127:0] rc_wbuf_rtn_data_o;
    logic [6:0]   wbuf_free_cnt_o;
`ifdef WBUF_RD_ERR_EN
    logic         wbuf_rd_err_o;
    logic [7:0]   wbuf_rd_err_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model
    bit           mv [N];
    logic [127:0] md [N];
    int           mfree;
    logic [127:0] pend [$];
    bit           merr;
    int           merr_cnt;

    always #5 clk = ~clk;

    wbuf_read_responder #(.ENTRIES_PER_CH(E)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .xbar_wbuf_valid_i        (xbar_wbuf_valid_i),
        .xbar_wbuf_ready_o        (xbar_wbuf_ready_o),
        .xbar_wbuf_channel_id_i   (xbar_wbuf_channel_id_i),
        .xbar_wbuf_wbuffer_id_i   (xbar_wbuf_wbuffer_id_i),
        .xbar_wbuf_data_i         (xbar_wbuf_data_i),
        .rc_wbuf_req_valid_i      (rc_wbuf_req_valid_i),
        .rc_wbuf_req_ready_o      (rc_wbuf_req_ready_o),
        .rc_wbuf_req_channel_id_i (rc_wbuf_req_channel_id_i),
        .rc_wbuf_req_wbuffer_id_i (rc_wbuf_req_wbuffer_id_i),
        .rc_wbuf_rtn_valid_o      (rc_wbuf_rtn_valid_o),
        .rc_wbuf_rtn_ready_i      (rc_wbuf_rtn_ready_i),
        .rc_wbuf_rtn_data_o       (rc_wbuf_rtn_data_o),
        .wbuf_free_cnt_o          (wbuf_free_cnt_o)
`ifdef WBUF_RD_ERR_EN
        ,
        .wbuf_rd_err_o            (wbuf_rd_err_o),
        .wbuf_rd_err_cnt_o        (wbuf_rd_err_cnt_o)
`endif
    );

    function automatic int midx(input logic [1:0] ch, input logic [7:0] id);
        return int'(ch) * E + (int'(id) % E);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        mfree    = N;
        pend.delete();
        merr     = 1'b0;
        merr_cnt = 0;
    endtask

    task automatic drive(input bit wv, input int wch, input int wid, input logic [127:0] wd,
                         input bit rv, input int rch, input int rid, input bit rrdy);
        xbar_wbuf_valid_i        = wv;
        xbar_wbuf_channel_id_i   = 2'(wch);
        xbar_wbuf_wbuffer_id_i   = 8'(wid);
        xbar_wbuf_data_i         = wd;
        rc_wbuf_req_valid_i      = rv;
        rc_wbuf_req_channel_id_i = 2'(rch);
        rc_wbuf_req_wbuffer_id_i = 8'(rid);
        rc_wbuf_rtn_ready_i      = rrdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0, 0, 1);
    endtask

    // Advance one clock and update the model from the inputs currently applied.
    task automatic tick();
        int wi, ri;
        bit wf, rf, rr;
        logic [127:0] wd;
        wi = midx(xbar_wbuf_channel_id_i, xbar_wbuf_wbuffer_id_i);
        ri = midx(rc_wbuf_req_channel_id_i, rc_wbuf_req_wbuffer_id_i);
        rr = rc_wbuf_rtn_ready_i;
        wd = xbar_wbuf_data_i;
        wf = xbar_wbuf_valid_i && !mv[wi];
        rf = rc_wbuf_req_valid_i && (pend.size() == 0 || rr);
        @(posedge clk);
        if (pend.size() != 0 && rr) void'(pend.pop_front());
        if (rf) begin
            pend.push_back(mv[ri] ? md[ri] : 128'h0);
            if (mv[ri]) begin
                mv[ri] = 1'b0;
                mfree++;
            end else begin
                merr = 1'b1;
                if (merr_cnt < 255) merr_cnt++;
            end
        end
        if (wf) begin
            md[wi] = wd;
            mv[wi] = 1'b1;
            mfree--;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++; if (rc_wbuf_rtn_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rtn_valid got=%b exp=0", rc_wbuf_rtn_valid_o); end
        total++; if (rc_wbuf_rtn_data_o !== 128'h0) begin bad++; $display("FAIL reset_rtn_data got=%h exp=0", rc_wbuf_rtn_data_o); end
        total++; if (wbuf_free_cnt_o !== 7'd16) begin bad++; $display("FAIL reset_free got=%0d exp=16", wbuf_free_cnt_o); end
        total++; if (rc_wbuf_req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", rc_wbuf_req_ready_o); end
`ifdef WBUF_RD_ERR_EN
        total++; if (wbuf_rd_err_o !== 1'b0 || wbuf_rd_err_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_err got=%b/%0d exp=0/0", wbuf_rd_err_o, wbuf_rd_err_cnt_o); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [127:0] a;
        a = rnd128();
        drive(1, 1, 2, a, 0, 0, 0, 1);
        #1;
        total++; if (xbar_wbuf_ready_o !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", xbar_wbuf_ready_o); end
        tick();
        total++; if (wbuf_free_cnt_o !== 7'd15) begin bad++; $display("FAIL wr_free got=%0d exp=15", wbuf_free_cnt_o); end
        drive(0, 0, 0, '0, 1, 1, 2, 1);
        tick();
        total++; if (rc_wbuf_rtn_valid_o !== 1'b1 || rc_wbuf_rtn_data_o !== a) begin bad++; $display("FAIL rd_data got=%b/%h exp=1/%h", rc_wbuf_rtn_valid_o, rc_wbuf_rtn_data_o, a); end
        total++; if (wbuf_free_cnt_o !== 7'd16) begin bad++; $display("FAIL rd_free got=%0d exp=16", wbuf_free_cnt_o); end
        idle();
        tick();
        total++; if (rc_wbuf_rtn_valid_o !== 1'b0) begin bad++; $display("FAIL rd_drop got=%b exp=0", rc_wbuf_rtn_valid_o); end
    endtask

    task automatic test_second_write();
        logic [127:0] a, b;
        a = rnd128();
        b = rnd128();
        drive(1, 1, 2, a, 0, 0, 0, 1);
        tick();
        drive(1, 1, 2, b, 0, 0, 0, 1);
        #1;
        total++; if (xbar_wbuf_ready_o !== 1'b0) begin bad++; $display("FAIL wr2_blocked got=%b exp=0", xbar_wbuf_ready_o); end
        tick();
        drive(1, 1, 2, b, 1, 1, 2, 1);
        #1;
        total++; if (xbar_wbuf_ready_o !== 1'b0) begin bad++; $display("FAIL wr2_blocked_rd got=%b exp=0", xbar_wbuf_ready_o); end
        tick();
        total++; if (rc_wbuf_rtn_data_o !== a) begin bad++; $display("FAIL wr2_first_data got=%h exp=%h", rc_wbuf_rtn_data_o, a); end
        drive(1, 1, 2, b, 0, 0, 0, 1);
        #1;
        total++; if (xbar_wbuf_ready_o !== 1'b1) begin bad++; $display("FAIL wr2_ready_after got=%b exp=1", xbar_wbuf_ready_o); end
        tick();
        drive(0, 0, 0, '0, 1, 1, 2, 1);
        tick();
        total++; if (rc_wbuf_rtn_data_o !== b) begin bad++; $display("FAIL wr2_second_data got=%h exp=%h", rc_wbuf_rtn_data_o, b); end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = rnd128();
            drive(1, 2, i, v[i], 0, 0, 0, 1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, '0, 1, 2, i, 1);
            #1;
            total++; if (rc_wbuf_req_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_req_ready[%0d] got=%b exp=1", i, rc_wbuf_req_ready_o); end
            tick();
            total++; if (rc_wbuf_rtn_valid_o !== 1'b1 || rc_wbuf_rtn_data_o !== v[i]) begin bad++; $display("FAIL b2b_beat[%0d] got=%b/%h exp=1/%h", i, rc_wbuf_rtn_valid_o, rc_wbuf_rtn_data_o, v[i]); end
        end
        idle();
        tick();
        // Backpressure: first beat stalls for three cycles with a second request waiting.
        for (int i = 0; i < 2; i++) begin
            drive(1, 2, i, v[i], 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, '0, 1, 2, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, '0, 1, 2, 1, 0);
            #1;
            total++; if (rc_wbuf_req_ready_o !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", c, rc_wbuf_req_ready_o); end
            tick();
            total++; if (rc_wbuf_rtn_valid_o !== 1'b1 || rc_wbuf_rtn_data_o !== v[0]) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", c, rc_wbuf_rtn_valid_o, rc_wbuf_rtn_data_o, v[0]); end
            total++; if (int'(wbuf_free_cnt_o) !== 15) begin bad++; $display("FAIL bp_free[%0d] got=%0d exp=15", c, wbuf_free_cnt_o); end
        end
        drive(0, 0, 0, '0, 1, 2, 1, 1);
        tick();
        total++; if (rc_wbuf_rtn_valid_o !== 1'b1 || rc_wbuf_rtn_data_o !== v[1]) begin bad++; $display("FAIL bp_second got=%b/%h exp=1/%h", rc_wbuf_rtn_valid_o, rc_wbuf_rtn_data_o, v[1]); end
        idle();
        tick();
        total++; if (rc_wbuf_rtn_valid_o !== 1'b0 || wbuf_free_cnt_o !== 7'd16) begin bad++; $display("FAIL bp_end got=%b/%0d exp=0/16", rc_wbuf_rtn_valid_o, wbuf_free_cnt_o); end
    endtask

    task automatic test_invalid_read();
        drive(0, 0, 0, '0, 1, 3, 0, 1);
        tick();
        total++; if (rc_wbuf_rtn_valid_o !== 1'b1 || rc_wbuf_rtn_data_o !== 128'h0) begin bad++; $display("FAIL inv_data got=%b/%h exp=1/0", rc_wbuf_rtn_valid_o, rc_wbuf_rtn_data_o); end
        total++; if (wbuf_free_cnt_o !== 7'd16) begin bad++; $display("FAIL inv_free got=%0d exp=16", wbuf_free_cnt_o); end
`ifdef WBUF_RD_ERR_EN
        total++; if (wbuf_rd_err_o !== 1'b1 || wbuf_rd_err_cnt_o !== 8'd1) begin bad++; $display("FAIL inv_err got=%b/%0d exp=1/1", wbuf_rd_err_o, wbuf_rd_err_cnt_o); end
`endif
        for (int i = 0; i < 299; i++) begin
            drive(0, 0, 0, '0, 1, 3, 0, 1);
            tick();
        end
        total++; if (rc_wbuf_rtn_data_o !== 128'h0) begin bad++; $display("FAIL inv300_data got=%h exp=0", rc_wbuf_rtn_data_o); end
`ifdef WBUF_RD_ERR_EN
        total++; if (wbuf_rd_err_cnt_o !== 8'd255 || wbuf_rd_err_o !== 1'b1) begin bad++; $display("FAIL inv300_cnt got=%b/%0d exp=1/255", wbuf_rd_err_o, wbuf_rd_err_cnt_o); end
`endif
        idle();
        tick();
    endtask

    task automatic test_same_cycle();
        logic [127:0] d;
        d = rnd128();
        drive(1, 0, 1, d, 1, 0, 1, 1);
        #1;
        total++; if (xbar_wbuf_ready_o !== 1'b1) begin bad++; $display("FAIL same_wr_ready got=%b exp=1", xbar_wbuf_ready_o); end
        tick();
        total++; if (rc_wbuf_rtn_data_o !== 128'h0) begin bad++; $display("FAIL same_rd_zero got=%h exp=0", rc_wbuf_rtn_data_o); end
        total++; if (wbuf_free_cnt_o !== 7'd15) begin bad++; $display("FAIL same_free got=%0d exp=15", wbuf_free_cnt_o); end
        drive(0, 0, 0, '0, 1, 0, 1, 1);
        tick();
        total++; if (rc_wbuf_rtn_data_o !== d) begin bad++; $display("FAIL same_follow got=%h exp=%h", rc_wbuf_rtn_data_o, d); end
        idle();
        tick();
    endtask

    task automatic test_random();
        int wi;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255), rnd128(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 3) != 0);
            #1;
            wi = midx(xbar_wbuf_channel_id_i, xbar_wbuf_wbuffer_id_i);
            total++; if (xbar_wbuf_ready_o !== !mv[wi]) begin bad++; $display("FAIL rnd_wr_ready[%0d] got=%b exp=%b", c, xbar_wbuf_ready_o, !mv[wi]); end
            total++; if (rc_wbuf_req_ready_o !== (pend.size() == 0 || rc_wbuf_rtn_ready_i)) begin bad++; $display("FAIL rnd_req_ready[%0d] got=%b", c, rc_wbuf_req_ready_o); end
            tick();
            total++; if (rc_wbuf_rtn_valid_o !== (pend.size() != 0)) begin bad++; $display("FAIL rnd_rtn_valid[%0d] got=%b exp=%b", c, rc_wbuf_rtn_valid_o, pend.size() != 0); end
            if (pend.size() != 0) begin
                total++; if (rc_wbuf_rtn_data_o !== pend[0]) begin bad++; $display("FAIL rnd_rtn_data[%0d] got=%h exp=%h", c, rc_wbuf_rtn_data_o, pend[0]); end
            end
            total++; if (int'(wbuf_free_cnt_o) !== mfree) begin bad++; $display("FAIL rnd_free[%0d] got=%0d exp=%0d", c, wbuf_free_cnt_o, mfree); end
`ifdef WBUF_RD_ERR_EN
            total++; if (wbuf_rd_err_o !== merr || int'(wbuf_rd_err_cnt_o) !== merr_cnt) begin bad++; $display("FAIL rnd_err[%0d] got=%b/%0d exp=%b/%0d", c, wbuf_rd_err_o, wbuf_rd_err_cnt_o, merr, merr_cnt); end
`endif
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [127:0] a;
        a = rnd128();
        drive(1, 1, 3, a, 0, 0, 0, 1);
        tick();
        drive(1, 2, 2, a, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, '0, 1, 1, 3, 0);
        tick();
        idle();
        rc_wbuf_rtn_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (rc_wbuf_rtn_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", rc_wbuf_rtn_valid_o); end
        total++; if (wbuf_free_cnt_o !== 7'd16) begin bad++; $display("FAIL rstmid_free got=%0d exp=16", wbuf_free_cnt_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 0, 0, '0, 1, 2, 2, 1);
        #1;
        total++; if (rc_wbuf_req_ready_o !== 1'b1) begin bad++; $display("FAIL rstmid_req_ready got=%b exp=1", rc_wbuf_req_ready_o); end
        tick();
        total++; if (rc_wbuf_rtn_data_o !== 128'h0 || wbuf_free_cnt_o !== 7'd16) begin bad++; $display("FAIL rstmid_unreadable got=%h/%0d exp=0/16", rc_wbuf_rtn_data_o, wbuf_free_cnt_o); end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_second_write();
        test_back_to_back();
        test_invalid_read();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
